// File: rtl/sine_step_ctrl.sv
// Sample-rate tick generator and quarter-wave sine table address sequencer.
// Divide-ratio updates are taken only at sample boundaries; a stop always completes the sine cycle.
module sine_step_ctrl #(
  parameter int unsigned DIV_WIDTH  = 10,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  div_value,
  input  logic                  div_load,
  output logic                  div_ack,
  output logic                  tick,
  output logic [ADDR_WIDTH-1:0] lut_addr,
  output logic [1:0]            quadrant,
  output logic                  negate,
  output logic                  running
);

  localparam int unsigned PhaseWidth = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]  div_active_q, div_active_d;
  logic [DIV_WIDTH-1:0]  pending_q, pending_d;
  logic                  pending_valid_q, pending_valid_d;
  logic [PhaseWidth-1:0] phase_q, phase_d;
  logic                  tick_q, tick_d;
  logic                  ack_q, ack_d;
  logic                  running_q, running_d;

  logic                  tick_now;
  logic                  apply;
  logic [ADDR_WIDTH-1:0] lo;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    phase_d         = phase_q;
    div_active_d    = div_active_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    ack_d           = 1'b0;

    tick_now = (state_q != StIdle) && (cnt_q == div_active_q);
    // Idle applies immediately; otherwise only on the edge closing a tick cycle.
    apply    = pending_valid_q && ((state_q == StIdle) || tick_now);

    if (apply) begin
      div_active_d    = pending_q;
      pending_valid_d = 1'b0;
      ack_d           = 1'b1;
    end
    // A load coinciding with a boundary becomes pending for the next one.
    if (div_load) begin
      pending_d       = div_value;
      pending_valid_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (enable) begin
          state_d = StRun;
        end
      end
      StRun, StStop: begin
        if (tick_now) begin
          cnt_d   = '0;
          phase_d = phase_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (enable) begin
          state_d = StRun;
        end else if (tick_now && (phase_q == {PhaseWidth{1'b1}})) begin
          state_d = StIdle;
        end else if (!tick_now && (phase_q == '0)) begin
          // No sample of this cycle issued yet: nothing to finish.
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          state_d = StStop;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    running_d = (state_d != StIdle);
    tick_d    = running_d && (cnt_d == div_active_d);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      div_active_q    <= '1;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      phase_q         <= '0;
      tick_q          <= 1'b0;
      ack_q           <= 1'b0;
      running_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      div_active_q    <= div_active_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      phase_q         <= phase_d;
      tick_q          <= tick_d;
      ack_q           <= ack_d;
      running_q       <= running_d;
    end
  end

  // Odd quadrants walk the quarter-wave table backwards.
  assign quadrant = phase_q[PhaseWidth-1 -: 2];
  assign lo       = phase_q[ADDR_WIDTH-1:0];
  assign lut_addr = quadrant[0] ? ~lo : lo;
  assign negate   = quadrant[1];
  assign tick     = tick_q;
  assign div_ack  = ack_q;
  assign running  = running_q;

endmodule

// File: tb/tb_sine_step_ctrl.sv
// Scoreboard bench for sine_step_ctrl: directed stimulus pushes expected ticks and acks,
// a negedge monitor pops and compares them whenever the DUT presents one.
module tb_sine_step_ctrl;

  localparam int unsigned DW = 4;
  localparam int unsigned AW = 2;

  logic          clk_in = 1'b0;
  logic          reset;
  logic          enable;
  logic [DW-1:0] div_value;
  logic          div_load;
  logic          div_ack;
  logic          tick;
  logic [AW-1:0] lut_addr;
  logic [1:0]    quadrant;
  logic          negate;
  logic          running;

  sine_step_ctrl #(
    .DIV_WIDTH (DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .enable   (enable),
    .div_value(div_value),
    .div_load (div_load),
    .div_ack  (div_ack),
    .tick     (tick),
    .lut_addr (lut_addr),
    .quadrant (quadrant),
    .negate   (negate),
    .running  (running)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int addr;
    int quad;
    int neg;
  } tick_t;

  tick_t tq[$];
  int    aq[$];
  int    n_checks = 0;
  int    n_fail = 0;

  int t4_addr[16] = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1, 2, 3, 3, 2, 1, 0};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic tick_t mk(input int c, input int ph);
    tick_t t;
    int lo, q;
    lo = ph % 4;
    q = (ph / 4) % 4;
    t.cyc = c;
    t.addr = (q % 2 == 1) ? (3 - lo) : lo;
    t.quad = q;
    t.neg = (q >= 2) ? 1 : 0;
    return t;
  endfunction

  task automatic exp_tick(input int c, input int ph);
    tq.push_back(mk(c, ph));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic load(input int v);
    div_value = DW'(v);
    div_load = 1'b1;
    step(1);
    div_load = 1'b0;
  endtask

  // Monitor: every presented tick/ack must match the head of its queue.
  always @(negedge clk_in) begin
    tick_t e;
    int    ea;
    if (tick === 1'b1) begin
      if (tq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_tick: got tick at cycle %0d, expected none", cyc);
      end else begin
        e = tq.pop_front();
        check("tick_cycle", cyc, e.cyc);
        check("tick_lut_addr", int'(lut_addr), e.addr);
        check("tick_quadrant", int'(quadrant), e.quad);
        check("tick_negate", int'(negate), e.neg);
      end
    end
    if (div_ack === 1'b1) begin
      if (aq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got div_ack at cycle %0d, expected none", cyc);
      end else begin
        ea = aq.pop_front();
        check("ack_cycle", cyc, ea);
      end
    end
  end

  initial begin
    int c0, c, c3, c4, c5, c6, r;
    reset = 1'b1;
    enable = 1'b0;
    div_load = 1'b0;
    div_value = '0;
    step(2);
    check("rst_tick", int'(tick), 0);
    check("rst_ack", int'(div_ack), 0);
    check("rst_running", int'(running), 0);
    check("rst_lut_addr", int'(lut_addr), 0);
    check("rst_quadrant", int'(quadrant), 0);
    check("rst_negate", int'(negate), 0);
    reset = 1'b0;
    step(1);

    // Default period 16, then stop requested after the phase-5 tick.
    c0 = cyc;
    enable = 1'b1;
    for (int k = 1; k <= 16; k++) exp_tick(c0 + 16 * k, k - 1);
    step(1);
    check("run_running", int'(running), 1);
    wait_to(c0 + 97);
    enable = 1'b0;
    wait_to(c0 + 256);
    check("stop_running_last_tick", int'(running), 1);
    step(1);
    check("stop_running_after", int'(running), 0);

    // Idle load of 3, then run at period 4 with mid-period and boundary loads.
    wait_to(c0 + 260);
    c = cyc;
    aq.push_back(c + 2);
    load(3);
    check("idle_ack_not_early", int'(div_ack), 0);
    wait_to(c + 4);
    c3 = cyc;
    enable = 1'b1;
    exp_tick(c3 + 4, 0);
    exp_tick(c3 + 8, 1);
    exp_tick(c3 + 12, 2);
    exp_tick(c3 + 14, 3);
    exp_tick(c3 + 16, 4);
    exp_tick(c3 + 18, 5);
    exp_tick(c3 + 21, 6);
    exp_tick(c3 + 24, 7);
    exp_tick(c3 + 25, 8);
    exp_tick(c3 + 29, 9);
    for (int p = 10; p <= 15; p++) exp_tick(c3 + 33 + 4 * (p - 10), p);
    aq.push_back(c3 + 13);
    aq.push_back(c3 + 19);
    aq.push_back(c3 + 25);
    aq.push_back(c3 + 26);
    step(1);
    check("div3_running", int'(running), 1);
    wait_to(c3 + 10);
    load(1);
    wait_to(c3 + 16);
    load(2);
    wait_to(c3 + 22);
    load(0);
    wait_to(c3 + 24);
    load(3);
    wait_to(c3 + 30);
    enable = 1'b0;
    wait_to(c3 + 54);
    check("stop2_running", int'(running), 0);

    // Divide 0: sixteen back-to-back ticks across all four quadrants.
    wait_to(c3 + 55);
    c4 = cyc;
    aq.push_back(c4 + 2);
    load(0);
    wait_to(c4 + 3);
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick_t t;
      t.cyc = c4 + 4 + i;
      t.addr = t4_addr[i];
      t.quad = i / 4;
      t.neg = (i >= 8) ? 1 : 0;
      tq.push_back(t);
    end
    wait_to(c4 + 19);
    enable = 1'b0;
    step(1);
    check("div0_stop_running", int'(running), 0);

    // Enable pulse that ends before any sample: straight back to idle, no ticks.
    wait_to(c4 + 22);
    c5 = cyc;
    aq.push_back(c5 + 2);
    load(15);
    wait_to(c5 + 4);
    enable = 1'b1;
    step(1);
    enable = 1'b0;
    check("pulse_running", int'(running), 1);
    step(1);
    check("pulse_idle", int'(running), 0);
    wait_to(c5 + 40);

    // Reset mid-period with a load pending: discarded, period back to 16.
    c6 = cyc;
    aq.push_back(c6 + 2);
    load(1);
    wait_to(c6 + 3);
    enable = 1'b1;
    exp_tick(c6 + 5, 0);
    exp_tick(c6 + 7, 1);
    exp_tick(c6 + 9, 2);
    exp_tick(c6 + 11, 3);
    wait_to(c6 + 12);
    load(2);
    check("pre_reset_quadrant", int'(quadrant), 1);
    #2;
    reset = 1'b1;
    enable = 1'b0;
    #1;
    check("async_rst_tick", int'(tick), 0);
    check("async_rst_running", int'(running), 0);
    check("async_rst_lut_addr", int'(lut_addr), 0);
    check("async_rst_quadrant", int'(quadrant), 0);
    check("async_rst_negate", int'(negate), 0);
    check("async_rst_ack", int'(div_ack), 0);
    step(2);
    reset = 1'b0;
    enable = 1'b1;
    r = cyc;
    exp_tick(r + 16, 0);
    exp_tick(r + 32, 1);
    wait_to(r + 36);

    check("ticks_outstanding", tq.size(), 0);
    check("acks_outstanding", aq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sine_step_ctrl.md
Name: sine_step_ctrl

Overview:
Sequencing controller for the sine-wave datapath. It produces a programmable sample-rate tick and steps a quarter-wave sine table address, with quadrant and sign outputs for the downstream LUT and negation stage. A load/ack handshake updates the divide ratio glitch-free, at sample-period boundaries only. A controlled stop always finishes the current full sine cycle.

Parameters:
DIV_WIDTH, 10, width of the divide-ratio register and period counter
ADDR_WIDTH, 8, quarter-wave LUT address width (full cycle = 2^(ADDR_WIDTH+2) samples)

Ports:
clk_in  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  level; high = run, low = stop at the end of the full sine cycle
div_value  input  DIV_WIDTH  new divide ratio; period = div_value+1 cycles
div_load  input  1  one-cycle strobe, captures div_value into the pending register
div_ack  output  1  one-cycle pulse when the pending value becomes active
tick  output  1  one-cycle sample strobe; lut_addr/quadrant/negate are valid while high
lut_addr  output  ADDR_WIDTH  mirrored quarter-wave table address
quadrant  output  2  phase[top 2 bits]
negate  output  1  quadrant[1]; downstream negates the LUT sample
running  output  1  high in RUN or STOP

Behaviour:
- Reset is asynchronous and active-high.
- Reset values: tick=0, div_ack=0, running=0, phase=0, so lut_addr=0, quadrant=0, negate=0. Also cnt=0, div_active = all ones, pending_valid=0, state=IDLE.
- Reset mid-operation: the current sample and any pending load are discarded, and all of the above values apply immediately.
- Registers: cnt[DIV_WIDTH], div_active[DIV_WIDTH], pending[DIV_WIDTH]+pending_valid, phase[ADDR_WIDTH+2].
- Decode (combinational from phase):
  - quadrant = phase[MSB:MSB-1]
  - lo = phase[ADDR_WIDTH-1:0]
  - lut_addr = quadrant[0] ? (2^ADDR_WIDTH-1 - lo) : lo
  - negate = quadrant[1]
- FSM states: IDLE, RUN, STOP.
  - IDLE: cnt held 0, no ticks. enable=1 -> RUN with cnt=0 and phase unchanged (0 after reset or a completed stop).
  - RUN: cnt increments each cycle. When cnt==div_active: tick=1 that cycle, cnt wraps to 0 and phase increments (mod 2^(ADDR_WIDTH+2)) at the closing edge. The tick cycle shows the pre-increment phase. enable=0 -> STOP.
  - STOP: counts and ticks exactly as RUN.
    - enable=1 -> RUN with no disturbance to cnt or phase.
    - At the tick where phase == all ones, phase wraps to 0 and the state goes to IDLE on the next edge.
    - If phase==0 and cnt==0 in STOP (no sample of the cycle issued yet), go to IDLE immediately.
- Period and rate:
  - Period = div_active+1 cycles.
  - div_active=0 gives a tick every cycle.
  - First tick after entering RUN arrives div_active+1 cycles later.
- Load handshake:
  - div_load=1: pending<=div_value, pending_valid<=1. A later load before application overwrites it (last wins, single ack).
  - In RUN/STOP: applied at a boundary, i.e. the edge closing a tick cycle. Sets div_active<=pending, pending_valid<=0, and div_ack=1 in the cycle following the tick.
  - In IDLE: applied on the edge after the load; div_ack high the next cycle.
  - Load in the same cycle as a boundary:
    - An older pending value is applied at this boundary.
    - The new value becomes pending for the next boundary.
    - With no older pending value, nothing is applied at this boundary.
- A change of div_active never truncates or extends the period already in progress.

Test Plan:
1. DIV_WIDTH=4, ADDR_WIDTH=2, reset released, enable=1, no loads -> first tick 16 cycles after RUN entry, then every 16 cycles; first tick shows lut_addr=0, quadrant=0, negate=0.
2. In IDLE, div_value=3 with div_load pulse -> div_ack one cycle two edges later; then enable=1 -> tick every 4 cycles, running=1.
3. RUN at period 4, load div_value=1 mid-period -> current period still 4; div_ack the cycle after that tick; following periods 2. Second load on a boundary cycle -> applied one boundary later.
4. ADDR_WIDTH=2, div 0, 16 consecutive ticks:
   - lut_addr = 0,1,2,3,3,2,1,0,0,1,2,3,3,2,1,0
   - quadrant = 0×4, 1×4, 2×4, 3×4
   - negate = 0 for the first 8 ticks, 1 for the last 8
5. enable dropped after the tick at phase 5 -> ticks continue through phase 15, running=0 after that tick, no further ticks; re-enable -> next tick shows phase 0. Separately: enable pulse then drop before the first tick -> immediate IDLE, no ticks.
6. reset asserted mid-period with a pending load -> outputs zero immediately and asynchronously, no div_ack; after release, period = 16 (div_active all ones).
